// File: rtl/reg_pkg.sv
// reg_pkg: shared register access modes and per-register mode lookup
package reg_pkg;
  localparam int MAX_REGS = 256;
  typedef enum logic [1:0] {
    REG_RW   = 2'd0,
    REG_RO   = 2'd1,
    REG_W1C  = 2'd2,
    REG_RSVD = 2'd3
  } reg_mode_t;
  function automatic reg_mode_t mode_of(input logic [2*MAX_REGS-1:0] modes, input int i);
    return reg_mode_t'(modes[2*i+:2]);
  endfunction
endpackage

// File: rtl/reg_cell.sv
// reg_cell: one bank register with RW, RO, W1C or reserved access behaviour
//  clk, rstn         clock, async active-low reset
//  we, wstrb, wdata  bus write enable for this register, byte lanes, data
//  hw_in, hw_set     RO value, W1C per-bit set pulses
//  q                 current register contents
module reg_cell
  import reg_pkg::*;
#(
  parameter int                DWIDTH    = 32,
  parameter reg_mode_t         MODE      = REG_RW,
  parameter logic [DWIDTH-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                we,
  input  logic [DWIDTH/8-1:0] wstrb,
  input  logic [DWIDTH-1:0]   wdata,
  input  logic [DWIDTH-1:0]   hw_in,
  input  logic [DWIDTH-1:0]   hw_set,
  output logic [DWIDTH-1:0]   q
);
  logic [DWIDTH-1:0] mask;
  logic              unused;
  assign unused = ^{clk, rstn, we, mask, wdata, hw_in, hw_set};
  for (genvar b = 0; b < DWIDTH / 8; b++) begin : g_lane
    assign mask[8*b+:8] = {8{wstrb[b]}};
  end
  if (MODE == REG_RW || MODE == REG_W1C) begin : g_store
    // W1C: hw_set is ORed in after the clear so a coincident set wins
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) q <= RESET_VAL;
      else if (MODE == REG_RW) q <= we ? (q & ~mask) | (wdata & mask) : q;
      else q <= (q & ~({DWIDTH{we}} & mask & wdata)) | hw_set;
  end else begin : g_hw
    assign q = MODE == REG_RO ? hw_in : '0;
  end
endmodule

// File: rtl/reg_bank.sv
// reg_bank: register-bus slave with per-register access modes and access strobes
//  clk, rstn                 clock, async active-low reset
//  raddr, rd, rdata          read port, rdata registered one cycle after rd
//  waddr, wr, wdata, wstrb   write port with byte-lane enables
//  hw_in, hw_set             RO values, W1C set pulses (one slice per register)
//  reg_out                   contents of every register
//  wr_pulse, rd_pulse        one-cycle per-register accepted-access strobes
module reg_bank
  import reg_pkg::*;
#(
  parameter int                              AWIDTH    = 2,
  parameter int                              DWIDTH    = 32,
  localparam int                             NREGS     = 2 ** AWIDTH,
  localparam int                             NBYTES    = DWIDTH / 8,
  parameter logic [2*NREGS-1:0]              MODES     = '0,
  parameter logic [DWIDTH*NREGS-1:0]         RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [AWIDTH-1:0]         raddr,
  input  logic                      rd,
  output logic [DWIDTH-1:0]         rdata,
  input  logic [AWIDTH-1:0]         waddr,
  input  logic                      wr,
  input  logic [DWIDTH-1:0]         wdata,
  input  logic [NBYTES-1:0]         wstrb,
  input  logic [DWIDTH*NREGS-1:0]   hw_in,
  input  logic [DWIDTH*NREGS-1:0]   hw_set,
  output logic [DWIDTH*NREGS-1:0]   reg_out,
  output logic [NREGS-1:0]          wr_pulse,
  output logic [NREGS-1:0]          rd_pulse
);
  localparam logic [2*MAX_REGS-1:0] MODES_X = (2*MAX_REGS)'(MODES);
  logic [DWIDTH-1:0] q [NREGS];
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    reg_cell #(
      .DWIDTH   (DWIDTH),
      .MODE     (mode_of(MODES_X, i)),
      .RESET_VAL(RESET_VAL[DWIDTH*i+:DWIDTH])
    ) u_cell (
      .clk   (clk),
      .rstn  (rstn),
      .we    (wr && waddr == AWIDTH'(i)),
      .wstrb (wstrb),
      .wdata (wdata),
      .hw_in (hw_in[DWIDTH*i+:DWIDTH]),
      .hw_set(hw_set[DWIDTH*i+:DWIDTH]),
      .q     (q[i])
    );
    assign reg_out[DWIDTH*i+:DWIDTH] = q[i];
  end
  // rdata samples the pre-update contents, so a same-edge write shows up on the next read
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rdata    <= '0;
      wr_pulse <= '0;
      rd_pulse <= '0;
    end else begin
      rdata    <= rd ? q[raddr] : rdata;
      wr_pulse <= wr ? NREGS'(1) << waddr : '0;
      rd_pulse <= rd ? NREGS'(1) << raddr : '0;
    end
endmodule
